uart_tx_mmio: RTL

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio_pkg.sv | 33 +++
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_mmio.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared register map, STATUS bit positions and FSM encoding for the MMIO UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_tx_mmio_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [31:0] TXDATA_OFF = 32'h0;
  localparam logic [31:0] STATUS_OFF = 32'h4;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; a push while full is accepted only alongside a pop.
// Head is read combinationally, so a pop consumes dout at the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA push into a FIFO, STATUS read / W1C overflow, 8N1 serial out.
// tx falls 2 cycles after a TXDATA store from idle; UART_TX_PARITY_EN adds an even parity bit.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sel,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t      state;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           overflow;
  logic           hit_tx;
  logic           hit_st;
  logic           push;
  logic           pop;
  logic           bit_end;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic [3:0]     cnt_sat;
  logic [31:0]    status;
  logic           unused_wdata;
`ifdef UART_TX_PARITY_EN
  logic           parity_bit;
`endif

  assign hit_tx       = (address == BASE_ADDR + TXDATA_OFF);
  assign hit_st       = (address == BASE_ADDR + STATUS_OFF);
  assign sel          = hit_tx || hit_st;
  assign push         = memwrite && hit_tx;
  assign bit_end      = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign pop          = !reset && !fifo_empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
  assign unused_wdata = ^writedata[31:8];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    cnt_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
    status = '0;
    status[ST_BUSY]               = (state != S_IDLE);
    status[ST_FULL]               = fifo_full;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_OVF]                = overflow;
    status[ST_CNT_LSB +: 4]       = cnt_sat;
  end

  assign readdata = hit_st ? status : 32'h0;

  // A dropped push and a W1C in the same cycle leave overflow set.
  always_ff @(posedge clk) begin
    if (reset)                                        overflow <= 1'b0;
    else if (push && fifo_full && !pop)               overflow <= 1'b1;
    else if (memwrite && hit_st && writedata[ST_OVF]) overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      baud_cnt <= (state == S_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      if (pop) begin
        shreg <= fifo_dout;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^fifo_dout;
`endif
      end
      // tx follows the state one cycle later, giving the 2-cycle store-to-start latency.
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) state <= S_START;
        end
        S_START: begin
          tx <= 1'b0;
          if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          tx <= shreg[0];
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bit_cnt == 3'd7) state <= S_PARITY;
`else
            if (bit_cnt == 3'd7) state <= S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx <= parity_bit;
          if (bit_end) state <= S_STOP;
        end
`endif
        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) state <= pop ? S_START : S_IDLE;
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
